// File: rtl/cpu_pkg.sv
// Shared CPU constants: instruction field positions, opcode values and the
// decoded-word record carried through the decode stage.
package cpu_pkg;

    localparam int TAM_INSTR = 32;
    localparam int TAM_IMM   = 16;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int RD_MSB  = 15;
    localparam int RD_LSB  = 11;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef struct packed {
        logic uses_imm;
        logic ext_side;
        logic two_complement;
        logic illegal;
    } imm_ctrl_t;

    typedef struct packed {
        logic [5:0]         opcode;
        logic [4:0]         rs;
        logic [4:0]         rt;
        logic [4:0]         rd;
        logic [TAM_IMM-1:0] imm;
        imm_ctrl_t          ctrl;
    } dec_word_t;

    // rd and imm overlap in the encoding; both are always extracted.
    function automatic dec_word_t split_fields(input logic [TAM_INSTR-1:0] instr,
                                               input imm_ctrl_t ctrl);
        dec_word_t d;
        d.opcode = instr[OPC_MSB:OPC_LSB];
        d.rs     = instr[RS_MSB:RS_LSB];
        d.rt     = instr[RT_MSB:RT_LSB];
        d.rd     = instr[RD_MSB:RD_LSB];
        d.imm    = instr[IMM_MSB:IMM_LSB];
        d.ctrl   = ctrl;
        return d;
    endfunction

endpackage

// File: rtl/imm_decode_stage_if.sv
// Fetch-side handshake plus decoded-output bundle of the decode stage.
interface imm_decode_stage_if;
    import cpu_pkg::*;

    logic                 in_valid;
    logic [TAM_INSTR-1:0] in_instr;
    logic                 in_ready;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [5:0]           opcode;
    logic [4:0]           rs;
    logic [4:0]           rt;
    logic [4:0]           rd;
    logic [TAM_IMM-1:0]   imm;
    logic                 ext_side;
    logic                 two_complement;
    logic                 uses_imm;
    logic                 illegal;
    logic [7:0]           illegal_count;

    modport slave (
        input  in_valid, in_instr, flush, out_ready,
        output in_ready, out_valid, opcode, rs, rt, rd, imm,
               ext_side, two_complement, uses_imm, illegal, illegal_count
    );

    modport master (
        output in_valid, in_instr, flush, out_ready,
        input  in_ready, out_valid, opcode, rs, rt, rd, imm,
               ext_side, two_complement, uses_imm, illegal, illegal_count
    );

endinterface

// File: rtl/imm_class_decode.sv
// Opcode classifier producing the immediate extender's control flags.
module imm_class_decode
    import cpu_pkg::*;
(
    input  logic [5:0] i_opcode,
    output imm_ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        unique case (i_opcode)
            OP_RTYPE: ;
            OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
            OP_SLTI, OP_SLTIU, OP_LW, OP_SW: begin
                o_ctrl.uses_imm       = 1'b1;
                o_ctrl.two_complement = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                o_ctrl.uses_imm = 1'b1;
            end
            OP_LUI: begin
                o_ctrl.uses_imm = 1'b1;
                o_ctrl.ext_side = 1'b1;
            end
            default: begin
                o_ctrl.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Decode-stage register: main output register plus one skid entry, feeding
// the immediate extender directly.
module imm_decode_stage
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    imm_decode_stage_if.slave   bus
);

    imm_ctrl_t  w_ctrl;
    dec_word_t  w_dec;
    logic       w_accept;
    logic       w_drain;

    dec_word_t  r_main;
    logic       r_main_valid;
    dec_word_t  r_skid;
    logic       r_skid_valid;
    logic [7:0] r_illegal_count;

    imm_class_decode u_class (
        .i_opcode (bus.in_instr[OPC_MSB:OPC_LSB]),
        .o_ctrl   (w_ctrl)
    );

    assign w_dec    = split_fields(bus.in_instr, w_ctrl);
    assign w_accept = bus.in_valid && !r_skid_valid;
    assign w_drain  = r_main_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main          <= '0;
            r_main_valid    <= 1'b0;
            r_skid          <= '0;
            r_skid_valid    <= 1'b0;
            r_illegal_count <= '0;
        end else if (bus.flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            if (w_drain && r_main.ctrl.illegal && r_illegal_count != 8'hFF)
                r_illegal_count <= r_illegal_count + 8'd1;

            // A full skid blocks input, so skid->main never races a new accept.
            if (w_drain && r_skid_valid) begin
                r_main       <= r_skid;
                r_skid_valid <= 1'b0;
            end else if (w_accept && (!r_main_valid || w_drain)) begin
                r_main       <= w_dec;
                r_main_valid <= 1'b1;
            end else if (w_accept) begin
                r_skid       <= w_dec;
                r_skid_valid <= 1'b1;
            end else if (w_drain) begin
                r_main_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready       = !r_skid_valid;
    assign bus.out_valid      = r_main_valid;
    assign bus.opcode         = r_main.opcode;
    assign bus.rs             = r_main.rs;
    assign bus.rt             = r_main.rt;
    assign bus.rd             = r_main.rd;
    assign bus.imm            = r_main.imm;
    assign bus.ext_side       = r_main.ctrl.ext_side;
    assign bus.two_complement = r_main.ctrl.two_complement;
    assign bus.uses_imm       = r_main.ctrl.uses_imm;
    assign bus.illegal        = r_main.ctrl.illegal;
    assign bus.illegal_count  = r_illegal_count;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: directed scenarios plus a
// randomized run against a two-deep FIFO reference model.
module tb_imm_decode_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imm_decode_stage_if bus();

    imm_decode_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // {uses_imm, ext_side, two_complement, illegal} from the opcode class table
    function automatic logic [3:0] ref_flags(input logic [5:0] op);
        if (op inside {6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23, 6'h2B})
            return 4'b1010;
        else if (op inside {6'h0C, 6'h0D, 6'h0E})
            return 4'b1000;
        else if (op == 6'h0F)
            return 4'b1100;
        else if (op == 6'h00)
            return 4'b0000;
        return 4'b0001;
    endfunction

    function automatic logic [31:0] extend(input logic [15:0] v, input logic side, input logic tc);
        if (side) return {v, 16'h0000};
        if (tc)   return {{16{v[15]}}, v};
        return {16'h0000, v};
    endfunction

    function automatic logic [5:0] pick_opcode();
        logic [5:0] legal [14];
        legal = '{6'h00, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                  6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
        if ($urandom_range(0, 3) == 0) return 6'($urandom);
        return legal[$urandom_range(0, 13)];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_instr = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.illegal_count !== 8'd0 ||
            bus.imm !== 16'd0 || {bus.uses_imm, bus.ext_side, bus.two_complement, bus.illegal} !== 4'd0)
            begin
            errors++;
            $display("FAIL reset_hold: out_valid=%b in_ready=%b cnt=%0d imm=%h, required 0/1/0/0000",
                     bus.out_valid, bus.in_ready, bus.illegal_count, bus.imm);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: out_valid=%b in_ready=%b, required 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_decode_classes();
        logic [31:0] w   [3];
        logic [31:0] ext [3];
        logic [3:0]  fl  [3];
        logic [31:0] got_ext;
        w   = '{32'h2008FFFC, 32'h3508FFFC, 32'h3C011234};
        ext = '{32'hFFFFFFFC, 32'h0000FFFC, 32'h12340000};
        fl  = '{4'b1010, 4'b1000, 4'b1100};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = w[i];
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.imm !== w[i][15:0] ||
                {bus.uses_imm, bus.ext_side, bus.two_complement, bus.illegal} !== fl[i]) begin
                errors++;
                $display("FAIL decode_%0d: valid=%b imm=%h flags=%b, required 1/%h/%b", i, bus.out_valid,
                         bus.imm, {bus.uses_imm, bus.ext_side, bus.two_complement, bus.illegal},
                         w[i][15:0], fl[i]);
            end
            got_ext = extend(bus.imm, bus.ext_side, bus.two_complement);
            checks++;
            if (got_ext !== ext[i]) begin
                errors++;
                $display("FAIL extend_%0d: got %h, required %h", i, got_ext, ext[i]);
            end
            if (i == 2) begin
                checks++;
                if (bus.rt !== 5'd1 || bus.opcode !== 6'h0F) begin
                    errors++;
                    $display("FAIL lui_fields: rt=%0d op=%h, required 1/0f", bus.rt, bus.opcode);
                end
            end
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] w [4];
        int idx = 0;
        int rcv = 0;
        for (int i = 0; i < 4; i++) w[i] = {6'h23, 26'($urandom)};
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = w[idx];
            checks++;
            if (bus.in_ready !== (k < 2)) begin
                errors++;
                $display("FAIL bp_in_ready_%0d: got %b, required %b", k, bus.in_ready, (k < 2));
            end
            if (k >= 1) begin
                checks++;
                if (bus.out_valid !== 1'b1 || {bus.opcode, bus.rs, bus.rt, bus.imm} !== w[0]) begin
                    errors++;
                    $display("FAIL bp_hold_%0d: valid=%b word=%h, required 1/%h", k, bus.out_valid,
                             {bus.opcode, bus.rs, bus.rt, bus.imm}, w[0]);
                end
            end
            if (bus.in_ready) idx++;
            tick();
        end
        checks++;
        if (idx != 2) begin
            errors++;
            $display("FAIL bp_accepted: got %0d, required 2", idx);
        end
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && rcv < 4; cyc++) begin
            bus.in_valid = (idx < 4);
            if (idx < 4) bus.in_instr = w[idx];
            if (bus.out_valid) begin
                checks++;
                if ({bus.opcode, bus.rs, bus.rt, bus.imm} !== w[rcv]) begin
                    errors++;
                    $display("FAIL bp_order_%0d: got %h, required %h", rcv,
                             {bus.opcode, bus.rs, bus.rt, bus.imm}, w[rcv]);
                end
                rcv++;
            end
            if (bus.in_valid && bus.in_ready) idx++;
            tick();
        end
        checks++;
        if (rcv != 4) begin
            errors++;
            $display("FAIL bp_count: received %0d, required 4", rcv);
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_dup: out_valid=%b, required 0", bus.out_valid);
        end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h2001_0001;
        tick();
        bus.in_instr = 32'h2002_0002;
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_fill: in_ready=%b out_valid=%b, required 0/1", bus.in_ready, bus.out_valid);
        end
        bus.flush = 1'b1;
        bus.in_instr = 32'hFC00_BEEF;
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: out_valid=%b in_ready=%b, required 0/1", bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_dropped_%0d: out_valid=%b word=%h, required no output", k,
                         bus.out_valid, {bus.opcode, bus.rs, bus.rt, bus.imm});
            end
        end
    endtask

    task automatic test_illegal_saturate();
        int sent = 0;
        int delivered = 0;
        pulse_reset();
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && delivered < 300; cyc++) begin
            bus.in_valid = (sent < 300);
            bus.in_instr = {6'h3F, 26'($urandom)};
            checks++;
            if (bus.illegal_count !== 8'((delivered > 255) ? 255 : delivered)) begin
                errors++;
                $display("FAIL ill_count_%0d: got %0d, required %0d", delivered, bus.illegal_count,
                         (delivered > 255) ? 255 : delivered);
            end
            if (bus.in_valid) begin
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL ill_in_ready_%0d: got %b, required 1", sent, bus.in_ready);
                end
                sent++;
            end
            if (bus.out_valid) begin
                checks++;
                if (bus.illegal !== 1'b1 || bus.uses_imm !== 1'b0) begin
                    errors++;
                    $display("FAIL ill_flag_%0d: illegal=%b uses_imm=%b, required 1/0", delivered,
                             bus.illegal, bus.uses_imm);
                end
                delivered++;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (delivered != 300 || bus.illegal_count !== 8'd255) begin
            errors++;
            $display("FAIL ill_saturate: delivered=%0d cnt=%0d, required 300/255", delivered, bus.illegal_count);
        end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] head;
        logic [3:0]  fl;
        int exp_cnt = 0;
        logic can_acc;
        pulse_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_instr  = {pick_opcode(), 26'($urandom)};
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 31) == 0);
            checks++;
            if (bus.out_valid !== (q.size() > 0) || bus.in_ready !== (q.size() < 2) ||
                bus.illegal_count !== 8'(exp_cnt)) begin
                errors++;
                $display("FAIL rand_state_%0d: valid=%b ready=%b cnt=%0d, required %b/%b/%0d", cyc,
                         bus.out_valid, bus.in_ready, bus.illegal_count, (q.size() > 0), (q.size() < 2), exp_cnt);
            end
            if (q.size() > 0) begin
                head = q[0];
                fl = ref_flags(head[31:26]);
                checks++;
                if ({bus.opcode, bus.rs, bus.rt, bus.imm} !== head || bus.rd !== head[15:11] ||
                    {bus.uses_imm, bus.ext_side, bus.two_complement, bus.illegal} !== fl) begin
                    errors++;
                    $display("FAIL rand_data_%0d: word=%h flags=%b, required %h/%b", cyc,
                             {bus.opcode, bus.rs, bus.rt, bus.imm},
                             {bus.uses_imm, bus.ext_side, bus.two_complement, bus.illegal}, head, fl);
                end
            end
            can_acc = (q.size() < 2);
            if (bus.flush) begin
                q.delete();
            end else begin
                if (q.size() > 0 && bus.out_ready) begin
                    head = q.pop_front();
                    fl = ref_flags(head[31:26]);
                    if (fl[0] && exp_cnt < 255) exp_cnt++;
                end
                if (bus.in_valid && can_acc) q.push_back(bus.in_instr);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h2008FFFC;
        tick();
        bus.in_instr = 32'hFC00_0001;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL arst_pre: out_valid=%b in_ready=%b, required 1/0", bus.out_valid, bus.in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.imm !== 16'd0 ||
            bus.opcode !== 6'd0 || bus.illegal_count !== 8'd0 ||
            {bus.uses_imm, bus.ext_side, bus.two_complement, bus.illegal} !== 4'd0) begin
            errors++;
            $display("FAIL arst_clear: out_valid=%b in_ready=%b imm=%h op=%h cnt=%0d, required 0/1/0000/00/0",
                     bus.out_valid, bus.in_ready, bus.imm, bus.opcode, bus.illegal_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_decode_classes();
        test_backpressure();
        test_flush();
        test_illegal_saturate();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
